// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants and a byte-lane merge helper, reused by the
// core bus adapters and the mock SRAM slave.
package axi4_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge new_word into old_word on the byte lanes whose strobe bit is set.
  function automatic logic [AXI_DATA_W-1:0] apply_wstrb(
    input logic [AXI_DATA_W-1:0] old_word,
    input logic [AXI_DATA_W-1:0] new_word,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < AXI_STRB_W; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mock_axi4_lite_sram.sv
// Behavioural AXI4-Lite SRAM slave: single-beat reads and writes, one
// outstanding transaction per direction, always OKAY, contents kept across reset.
module mock_axi4_lite_sram
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic [3:0]        awcache,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  input  logic [3:0]        arcache,
  output logic              rvalid,
  input  logic              rready,
  output logic [1:0]        rresp,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx;
  logic              aw_fire;
  logic              ar_fire;
  logic              bvalid_q, bvalid_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              unused_bits;

  // Only the word-index bits matter; everything else wraps modulo DEPTH*4.
  assign w_idx = awaddr[IDX_W+1:2];
  assign r_idx = araddr[IDX_W+1:2];
  assign unused_bits = ^{awprot, awcache, arprot, arcache,
                         awaddr[ADDR_W-1:IDX_W+2], awaddr[1:0],
                         araddr[ADDR_W-1:IDX_W+2], araddr[1:0]};

  // AW and W are taken together, and only while no write response is pending.
  assign aw_fire = awvalid & wvalid & ~bvalid_q;
  assign ar_fire = arvalid & ~rvalid_q;

  assign awready = aw_fire;
  assign wready  = aw_fire;
  assign arready = ~rvalid_q;
  assign bvalid  = bvalid_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign bresp   = RESP_OKAY;
  assign rresp   = RESP_OKAY;

  always_comb begin
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (aw_fire) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = mem[r_idx];
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // The read above samples mem before this edge's write lands, giving read-first.
  always_ff @(posedge clock) begin
    if (!reset && aw_fire) begin
      mem[w_idx] <= apply_wstrb(mem[w_idx], wdata, wstrb);
    end
  end

endmodule

// File: tb/tb_mock_axi4_lite_sram.sv
// Scoreboard bench for mock_axi4_lite_sram: stimulus queues expected B/R
// responses on acceptance, a negedge monitor pops and compares on handshake.
module tb_mock_axi4_lite_sram;

  localparam int DEPTH = 16384;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  awcache, arcache, wstrb;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;
  logic [31:0] r_exp_q[$];
  logic [1:0]  b_exp_q[$];

  always #5 clock = ~clock;

  mock_axi4_lite_sram #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awcache(awcache),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arcache(arcache),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && rvalid && rready) begin
      if (r_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL r_unexpected actual=%h required=none", rdata);
      end else begin
        check("rdata", rdata, r_exp_q.pop_front());
        check("rresp", 32'(rresp), 32'd0);
      end
    end
    if (!reset && bvalid && bready) begin
      if (b_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected actual=%h required=none", bresp);
      end else begin
        check("bresp", 32'(bresp), 32'(b_exp_q.pop_front()));
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic ok;
    @(posedge clock); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (awready && wready) begin
        ok = 1'b1;
        b_exp_q.push_back(2'b00);
        break;
      end
    end
    check("aw_accept", 32'(ok), 32'd1);
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp);
    logic ok;
    @(posedge clock); #1;
    arvalid = 1'b1; araddr = addr;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (arready) begin
        ok = 1'b1;
        r_exp_q.push_back(exp);
        break;
      end
    end
    check("ar_accept", 32'(ok), 32'd1);
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (r_exp_q.size() == 0 && b_exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_state();
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    awaddr = 32'h0; araddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    awprot = 3'd0; arprot = 3'd0; awcache = 4'd0; arcache = 4'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state();
    #1 reset = 1'b0;

    // Preload through the bus, then reset again: contents must survive.
    axi_write(32'h0000_0000, 32'hDEAD_BEEF, 4'hF);
    axi_write(32'h0000_0010, 32'h1122_3344, 4'hF);
    axi_write(32'h0000_0020, 32'h0000_0005, 4'hF);
    axi_write(32'h0000_0004, 32'hCAFE_F00D, 4'hF);
    axi_write(32'h0000_0050, 32'h0000_0055, 4'hF);
    drain();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state();

    // Read 0x0 with rready low: response held stable, arready low.
    rready = 1'b0;
    @(posedge clock); #1 arvalid = 1'b1; araddr = 32'h0;
    @(negedge clock);
    check("ar_ready_idle", 32'(arready), 32'd1);
    r_exp_q.push_back(32'hDEAD_BEEF);
    @(posedge clock); #1 arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_rvalid", 32'(rvalid), 32'd1);
      check("hold_rdata", rdata, 32'hDEAD_BEEF);
      check("hold_arready", 32'(arready), 32'd0);
    end
    @(posedge clock); #1 rready = 1'b1;
    drain();

    // Full write to tohost, then read back.
    @(posedge clock); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h6000; wdata = 32'h1; wstrb = 4'hF;
    @(negedge clock);
    check("full_awready", 32'(awready), 32'd1);
    check("full_wready", 32'(wready), 32'd1);
    b_exp_q.push_back(2'b00);
    @(posedge clock); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clock);
    check("full_bvalid", 32'(bvalid), 32'd1);
    drain();
    axi_read(32'h6000, 32'h0000_0001);

    // Byte strobes, then an empty strobe that must still respond.
    axi_write(32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
    axi_read(32'h0000_0010, 32'h11BB_33DD);
    axi_write(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
    axi_read(32'h0000_0010, 32'h11BB_33DD);
    drain();

    // Channel skew and B backpressure.
    bready = 1'b0;
    @(posedge clock); #1 awvalid = 1'b1; awaddr = 32'h30; wdata = 32'h1234_5678; wstrb = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("skew_awready", 32'(awready), 32'd0);
      check("skew_bvalid", 32'(bvalid), 32'd0);
    end
    @(posedge clock); #1 wvalid = 1'b1;
    @(negedge clock);
    check("skew_accept", 32'(awready), 32'd1);
    b_exp_q.push_back(2'b00);
    @(posedge clock); #1 awaddr = 32'h34; wdata = 32'h9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_awready", 32'(awready), 32'd0);
    end
    @(posedge clock); #1 bready = 1'b1;
    @(negedge clock);
    check("bp_hs_awready", 32'(awready), 32'd0);
    @(negedge clock);
    check("bp_second_accept", 32'(awready), 32'd1);
    b_exp_q.push_back(2'b00);
    @(posedge clock); #1 awvalid = 1'b0; wvalid = 1'b0;
    drain();
    axi_read(32'h30, 32'h1234_5678);
    axi_read(32'h34, 32'h9ABC_DEF0);
    drain();

    // Same-cycle read and write to one word: read-first.
    @(posedge clock); #1;
    arvalid = 1'b1; araddr = 32'h20;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h20; wdata = 32'h9; wstrb = 4'hF;
    @(negedge clock);
    check("rw_arready", 32'(arready), 32'd1);
    check("rw_awready", 32'(awready), 32'd1);
    r_exp_q.push_back(32'h5);
    b_exp_q.push_back(2'b00);
    @(posedge clock); #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    drain();
    axi_read(32'h20, 32'h9);
    axi_read(DEPTH * 4 + 32'h4, 32'hCAFE_F00D);
    drain();

    // Reset with a read pending and a write presented during reset.
    rready = 1'b0;
    @(posedge clock); #1 arvalid = 1'b1; araddr = 32'h6000;
    @(negedge clock);
    check("mid_arready", 32'(arready), 32'd1);
    @(posedge clock); #1 arvalid = 1'b0;
    @(negedge clock);
    check("mid_rvalid", 32'(rvalid), 32'd1);
    check("mid_rdata", rdata, 32'h1);
    @(posedge clock); #1;
    reset = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h50; wdata = 32'h77; wstrb = 4'hF;
    @(posedge clock); #1;
    reset = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1;
    @(negedge clock);
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    check("post_rst_rdata", rdata, 32'd0);
    check("post_rst_bvalid", 32'(bvalid), 32'd0);
    axi_read(32'h6000, 32'h1);
    axi_read(32'h50, 32'h55);
    axi_read(32'h0, 32'hDEAD_BEEF);
    drain();

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
